// File: rtl/fb_pixel_writer_if.sv
// Pixel-stream input and framebuffer write-port bundle for fb_pixel_writer.
// The slave modport is the writer's view; master is the producer/memory side.
interface fb_pixel_writer_if #(
    parameter int unsigned SIZE    = 16,
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned COLOR_W = 12
);
    logic               pix_valid;
    logic               pix_ready;
    logic [SIZE-1:0]    pix_x;
    logic [SIZE-1:0]    pix_y;
    logic               pix_last;
    logic [COLOR_W-1:0] color;
    logic               fb_req;
    logic [ADDR_W-1:0]  fb_addr;
    logic [COLOR_W-1:0] fb_data;
    logic               fb_ack;

    modport master (
        output pix_valid, pix_x, pix_y, pix_last, color, fb_ack,
        input  pix_ready, fb_req, fb_addr, fb_data
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_last, color, fb_ack,
        output pix_ready, fb_req, fb_addr, fb_data
    );
endinterface

// File: rtl/fb_pixel_writer.sv
// Clips incoming pixels, converts them to linear framebuffer addresses, queues them
// and drains the queue to memory over a req/ack port, pulsing prim_done per primitive.
module fb_pixel_writer #(
    parameter int unsigned SIZE       = 16,
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned COLOR_W    = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_enb,
    fb_pixel_writer_if.slave    bus,
    output logic                busy,
    output logic                prim_done,
    output logic [15:0]         clip_count
);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned ProdW = SIZE + ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
        logic               last;
        logic               is_null;
    } entry_t;

    typedef enum logic {StIdle, StReq} state_e;

    entry_t             fifo_q [FIFO_DEPTH];
    entry_t             fifo_d [FIFO_DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    state_e             state_q, state_d;
    logic               fb_req_q, fb_req_d;
    logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
    logic [COLOR_W-1:0] fb_data_q, fb_data_d;
    logic               cur_last_q, cur_last_d;
    logic               null_pend_q, null_pend_d;
    logic               prim_done_q, prim_done_d;
    logic [15:0]        clip_count_q, clip_count_d;

    logic   fifo_full, fifo_empty, pix_ready, accept, clipped, push, pop;
    entry_t push_entry, head;

    always_comb begin
        fifo_full  = (count_q == CntW'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        pix_ready  = clk_enb & ~fifo_full;
        accept     = bus.pix_valid & pix_ready;
        clipped    = (ProdW'(bus.pix_x) >= ProdW'(H_RES)) | (ProdW'(bus.pix_y) >= ProdW'(V_RES));
        push       = accept & (~clipped | bus.pix_last);
        push_entry.addr    = ADDR_W'(ProdW'(bus.pix_y) * ProdW'(H_RES) + ProdW'(bus.pix_x));
        push_entry.color   = bus.color;
        push_entry.last    = bus.pix_last;
        push_entry.is_null = clipped;
        head       = fifo_q[rd_ptr_q];
    end

    // Write FSM; a null entry retiring right behind a last write defers its pulse one cycle.
    always_comb begin
        state_d     = state_q;
        fb_req_d    = fb_req_q;
        fb_addr_d   = fb_addr_q;
        fb_data_d   = fb_data_q;
        cur_last_d  = cur_last_q;
        null_pend_d = null_pend_q;
        prim_done_d = 1'b0;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (null_pend_q) begin
                    prim_done_d = 1'b1;
                    null_pend_d = 1'b0;
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head.is_null) begin
                        prim_done_d = 1'b1;
                    end else begin
                        fb_req_d   = 1'b1;
                        fb_addr_d  = head.addr;
                        fb_data_d  = head.color;
                        cur_last_d = head.last;
                        state_d    = StReq;
                    end
                end
            end
            StReq: begin
                if (bus.fb_ack) begin
                    prim_done_d = cur_last_q;
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        if (head.is_null) begin
                            fb_req_d = 1'b0;
                            state_d  = StIdle;
                            if (cur_last_q) null_pend_d = 1'b1;
                            else            prim_done_d = 1'b1;
                        end else begin
                            fb_addr_d  = head.addr;
                            fb_data_d  = head.color;
                            cur_last_d = head.last;
                        end
                    end else begin
                        fb_req_d = 1'b0;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fifo_d = fifo_q;
        if (push) fifo_d[wr_ptr_q] = push_entry;
        wr_ptr_d = wr_ptr_q + PtrW'(push);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        count_d  = count_q + CntW'(push) - CntW'(pop);
        clip_count_d = clip_count_q;
        if (accept && clipped && clip_count_q != 16'hFFFF) clip_count_d = clip_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= StIdle;
            fb_req_q     <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            cur_last_q   <= 1'b0;
            null_pend_q  <= 1'b0;
            prim_done_q  <= 1'b0;
            clip_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            fb_req_q     <= fb_req_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            cur_last_q   <= cur_last_d;
            null_pend_q  <= null_pend_d;
            prim_done_q  <= prim_done_d;
            clip_count_q <= clip_count_d;
        end
    end

    assign bus.pix_ready = pix_ready;
    assign bus.fb_req    = fb_req_q;
    assign bus.fb_addr   = fb_addr_q;
    assign bus.fb_data   = fb_data_q;
    assign busy          = ~fifo_empty | fb_req_q;
    assign prim_done     = prim_done_q;
    assign clip_count    = clip_count_q;
endmodule

// File: tb/tb_fb_pixel_writer.sv
// Randomised self-checking bench for fb_pixel_writer against a queue-based reference model.
module tb_fb_pixel_writer;
    localparam int unsigned SIZE       = 16;
    localparam int unsigned H_RES      = 640;
    localparam int unsigned V_RES      = 480;
    localparam int unsigned ADDR_W     = 19;
    localparam int unsigned COLOR_W    = 12;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned WW         = ADDR_W + COLOR_W;

    typedef logic [WW-1:0] wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_enb = 1'b0;
    logic        busy, prim_done;
    logic [15:0] clip_count;

    fb_pixel_writer_if #(.SIZE(SIZE), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) bus ();

    fb_pixel_writer #(
        .SIZE(SIZE), .H_RES(H_RES), .V_RES(V_RES),
        .ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .clk_enb(clk_enb), .bus(bus),
        .busy(busy), .prim_done(prim_done), .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  ack_mode = 0;  // 0 none, 1 ack while req, 2 random while req, 3 always high
    int  done_cnt = 0;
    int  req_cycles = 0;
    int  exp_clip = 0;
    int  exp_done = 0;
    wr_t obs_q[$];
    wr_t exp_q[$];

    // Memory responder
    always @(posedge clk) begin
        #2;
        case (ack_mode)
            1:       bus.fb_ack = bus.fb_req;
            2:       bus.fb_ack = bus.fb_req & ($urandom_range(0, 1) == 1);
            3:       bus.fb_ack = 1'b1;
            default: bus.fb_ack = 1'b0;
        endcase
    end

    // Observed writes and pulses
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.fb_req && bus.fb_ack) obs_q.push_back({bus.fb_addr, bus.fb_data});
            if (prim_done) done_cnt++;
            if (bus.fb_req) req_cycles++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_accept(input int x, input int y, input logic [COLOR_W-1:0] c,
                                input logic last);
        int unsigned a;
        if (x < int'(H_RES) && y < int'(V_RES)) begin
            a = y * H_RES + x;
            exp_q.push_back({a[ADDR_W-1:0], c});
        end else if (exp_clip < 65535) begin
            exp_clip++;
        end
        if (last) exp_done++;
    endtask

    task automatic send_pix(input int x, input int y, input logic [COLOR_W-1:0] c,
                            input logic last);
        logic acc;
        bus.pix_x = SIZE'(x);
        bus.pix_y = SIZE'(y);
        bus.color = c;
        bus.pix_last = last;
        bus.pix_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            #1;
            acc = bus.pix_ready;
            tick();
            if (acc) begin
                bus.pix_valid = 1'b0;
                model_accept(x, y, c, last);
                return;
            end
        end
        bus.pix_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL send_timeout: pixel (%0d,%0d) not accepted, required acceptance", x, y);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 3000; n++) begin
            if (!busy) begin
                repeat (4) tick();
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout: busy=%0d, required 0", busy);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clk_enb = 1'b1;
        bus.pix_valid = 1'b0;
        ack_mode = 0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        checks += 7;
        if (bus.pix_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.pix_ready); end
        if (bus.fb_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.fb_req); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (clip_count !== 16'd0) begin errors++; $display("FAIL reset_clip: got %0d want 0", clip_count); end
        if (bus.fb_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", bus.fb_addr); end
        if (bus.fb_data !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", bus.fb_data); end
        if (prim_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", prim_done); end
        repeat (8) tick();
        checks += 2;
        if (done_cnt !== 0) begin errors++; $display("FAIL idle_done: got %0d pulses want 0", done_cnt); end
        if (req_cycles !== 0) begin errors++; $display("FAIL idle_req: got %0d req cycles want 0", req_cycles); end
    endtask

    task automatic test_single();
        ack_mode = 1;
        bus.pix_x = 16'd3;
        bus.pix_y = 16'd2;
        bus.color = 12'hABC;
        bus.pix_last = 1'b1;
        bus.pix_valid = 1'b1;
        #1;
        checks++;
        if (bus.pix_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", bus.pix_ready); end
        tick();
        bus.pix_valid = 1'b0;
        model_accept(3, 2, 12'hABC, 1'b1);
        checks++;
        if (bus.fb_req !== 1'b0) begin errors++; $display("FAIL single_req_early: got %b want 0", bus.fb_req); end
        tick();
        checks += 3;
        if (bus.fb_req !== 1'b1) begin errors++; $display("FAIL single_req: got %b want 1", bus.fb_req); end
        if (bus.fb_addr !== 19'd1283) begin errors++; $display("FAIL single_addr: got %0d want 1283", bus.fb_addr); end
        if (bus.fb_data !== 12'hABC) begin errors++; $display("FAIL single_data: got %h want abc", bus.fb_data); end
        tick();
        checks += 2;
        if (prim_done !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", prim_done); end
        if (bus.fb_req !== 1'b0) begin errors++; $display("FAIL single_req_drop: got %b want 0", bus.fb_req); end
        tick();
        checks++;
        if (prim_done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b want 0", prim_done); end
        wait_idle();
        checks += 2;
        if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0])
            begin errors++; $display("FAIL single_write: got %0d writes want 1 matching model", obs_q.size()); end
        if (done_cnt !== exp_done) begin errors++; $display("FAIL single_pulses: got %0d want %0d", done_cnt, exp_done); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_clip();
        int req_before;
        ack_mode = 1;
        req_before = req_cycles;
        send_pix(640, 0, 12'h111, 1'b0);
        send_pix(0, 480, 12'h222, 1'b1);
        wait_idle();
        checks += 5;
        if (req_cycles !== req_before) begin errors++; $display("FAIL clip_req: got %0d req cycles want %0d", req_cycles, req_before); end
        if (clip_count !== 16'(exp_clip)) begin errors++; $display("FAIL clip_count: got %0d want %0d", clip_count, exp_clip); end
        if (done_cnt !== exp_done) begin errors++; $display("FAIL clip_done: got %0d want %0d", done_cnt, exp_done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL clip_busy: got %b want 0", busy); end
        if (obs_q.size() != 0) begin errors++; $display("FAIL clip_writes: got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        int accepted = 0;
        int stall_at = -1;
        int gaps = 0;
        logic r;
        logic [COLOR_W-1:0] col [6];
        ack_mode = 0;
        for (int i = 0; i < 6; i++) col[i] = COLOR_W'($urandom);
        for (int n = 0; n < 200 && (accepted < 6 || obs_q.size() < 6); n++) begin
            if (accepted < 6) begin
                bus.pix_x = SIZE'(accepted);
                bus.pix_y = 16'd10;
                bus.color = col[accepted];
                bus.pix_last = 1'b0;
                bus.pix_valid = 1'b1;
            end else begin
                bus.pix_valid = 1'b0;
            end
            #1;
            r = bus.pix_ready & bus.pix_valid;
            if (accepted < 6 && !bus.pix_ready && stall_at < 0) begin
                stall_at = accepted;
                repeat (3) tick();  // hold off the memory a little longer before acking
                ack_mode = 1;
            end
            tick();
            if (r) begin
                model_accept(accepted, 10, col[accepted], 1'b0);
                accepted++;
            end
            if (ack_mode == 1 && obs_q.size() < 6 && !bus.fb_req) gaps++;
        end
        bus.pix_valid = 1'b0;
        wait_idle();
        checks += 3;
        if (stall_at !== int'(FIFO_DEPTH) + 1)
            begin errors++; $display("FAIL b2b_stall: ready fell after %0d accepts want %0d", stall_at, FIFO_DEPTH + 1); end
        if (gaps !== 0) begin errors++; $display("FAIL b2b_gaps: fb_req low %0d cycles while draining want 0", gaps); end
        if (obs_q.size() != 6) begin errors++; $display("FAIL b2b_count: got %0d writes want 6", obs_q.size()); end
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i])
                begin errors++; $display("FAIL b2b_write%0d: got addr %0d want %0d", i, obs_q[i][WW-1:COLOR_W], exp_q[i][WW-1:COLOR_W]); end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_clk_enb();
        int got_ready = 0;
        ack_mode = 0;
        clk_enb = 1'b1;
        send_pix(7, 7, 12'h5A5, 1'b1);
        tick();
        clk_enb = 1'b0;
        bus.pix_x = 16'd8;
        bus.pix_y = 16'd8;
        bus.color = 12'h0F0;
        bus.pix_last = 1'b1;
        bus.pix_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.pix_ready !== 1'b0) got_ready++;
            tick();
        end
        checks++;
        if (got_ready !== 0) begin errors++; $display("FAIL enb_ready: ready high %0d cycles want 0", got_ready); end
        ack_mode = 1;
        wait_idle();
        bus.pix_valid = 1'b0;
        checks += 3;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0])
            begin errors++; $display("FAIL enb_write: got %0d writes want 1 matching model", obs_q.size()); end
        if (done_cnt !== exp_done) begin errors++; $display("FAIL enb_done: got %0d want %0d", done_cnt, exp_done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL enb_busy: got %b want 0", busy); end
        clk_enb = 1'b1;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        logic pend = 1'b0;
        logic acc;
        int x, y;
        logic last;
        logic [COLOR_W-1:0] c;
        ack_mode = 2;
        for (int n = 0; n < 400; n++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                x = $urandom_range(0, 700);
                y = $urandom_range(0, 520);
                last = ($urandom_range(0, 3) == 0);
                c = COLOR_W'($urandom);
                pend = 1'b1;
                bus.pix_x = SIZE'(x);
                bus.pix_y = SIZE'(y);
                bus.color = c;
                bus.pix_last = last;
            end
            bus.pix_valid = pend;
            clk_enb = ($urandom_range(0, 3) != 0);
            #1;
            acc = bus.pix_ready & pend;
            tick();
            if (acc) begin
                model_accept(x, y, c, last);
                pend = 1'b0;
            end
        end
        bus.pix_valid = 1'b0;
        clk_enb = 1'b1;
        wait_idle();
        checks += 3;
        if (obs_q.size() != exp_q.size())
            begin errors++; $display("FAIL rand_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
        if (clip_count !== 16'(exp_clip)) begin errors++; $display("FAIL rand_clip: got %0d want %0d", clip_count, exp_clip); end
        if (done_cnt !== exp_done) begin errors++; $display("FAIL rand_done: got %0d want %0d", done_cnt, exp_done); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i])
                begin errors++; $display("FAIL rand_write%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midwrite();
        int done_before, req_before;
        ack_mode = 0;
        clk_enb = 1'b1;
        for (int i = 0; i < 4; i++) send_pix(20 + i, 30, 12'h777, 1'b1);
        checks += 2;
        if (bus.fb_req !== 1'b1) begin errors++; $display("FAIL mid_req_pre: got %b want 1", bus.fb_req); end
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %b want 1", busy); end
        done_before = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_clip = 0;
        exp_done = done_before;
        checks += 4;
        if (bus.fb_req !== 1'b0) begin errors++; $display("FAIL mid_req: got %b want 0", bus.fb_req); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (prim_done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b want 0", prim_done); end
        if (clip_count !== 16'(exp_clip)) begin errors++; $display("FAIL mid_clip: got %0d want 0", clip_count); end
        req_before = req_cycles;
        ack_mode = 3;
        repeat (8) tick();
        ack_mode = 0;
        checks += 4;
        if (obs_q.size() != 0) begin errors++; $display("FAIL mid_writes: got %0d want 0", obs_q.size()); end
        if (done_cnt !== exp_done) begin errors++; $display("FAIL mid_pulses: got %0d want %0d", done_cnt, exp_done); end
        if (req_cycles !== req_before) begin errors++; $display("FAIL mid_req_later: got %0d want %0d", req_cycles, req_before); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_later: got %b want 0", busy); end
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_x = '0;
        bus.pix_y = '0;
        bus.pix_last = 1'b0;
        bus.color = '0;
        test_reset();
        test_single();
        test_clip();
        test_back_to_back();
        test_clk_enb();
        test_random();
        test_reset_midwrite();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end
endmodule
